// File: rtl/text_buf_arbiter.sv
// Character text buffer for the 16x16 text box: two round-robin write ports,
// a whole-buffer clear engine and a one-cycle registered read for the renderer.
module text_buf_arbiter #(
  parameter bit         SYNC_WR   = 1'b1,
  parameter logic [6:0] FILL_CODE = 7'h20
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       vblnk_in,
  input  logic [7:0] char_xy,
  output logic [6:0] char_code,
  input  logic       req0,
  input  logic [7:0] addr0,
  input  logic [6:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] addr1,
  input  logic [6:0] data1,
  output logic       ack1,
  input  logic       clr_req,
  output logic       clr_busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  logic [6:0] mem [256];

  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic [8:0] cnt_q, cnt_d;
  logic       ack0_q, ack0_d;
  logic       ack1_q, ack1_d;
  logic       clr_busy_q, clr_busy_d;
  logic [6:0] char_code_q;

  logic       wr_ok;
  logic       valid0, valid1, grant1;
  logic       we_raw, mem_we;
  logic [7:0] mem_waddr;
  logic [6:0] mem_wdata;

  assign wr_ok  = !SYNC_WR || vblnk_in;
  // A port whose ack is showing this cycle is not eligible, so a held request
  // cannot win twice in a row while the other port waits.
  assign valid0 = req0 && !ack0_q;
  assign valid1 = req1 && !ack1_q;
  assign grant1 = valid1 && (!valid0 || !last_q);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    we_raw    = 1'b0;
    mem_waddr = cnt_q[7:0];
    mem_wdata = FILL_CODE;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = 9'd0;
        end else if (wr_ok && (valid0 || valid1)) begin
          we_raw = 1'b1;
          if (grant1) begin
            mem_waddr = addr1;
            mem_wdata = data1;
            ack1_d    = 1'b1;
            last_d    = 1'b1;
          end else begin
            mem_waddr = addr0;
            mem_wdata = data0;
            ack0_d    = 1'b1;
            last_d    = 1'b0;
          end
        end
      end
      CLEAR: begin
        if (wr_ok) begin
          we_raw = 1'b1;
          cnt_d  = cnt_q + 9'd1;
          if (cnt_d[8]) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    clr_busy_d = (state_d == CLEAR);
  end

  // Reset suppresses the write of that cycle; buffer contents are otherwise untouched.
  assign mem_we = we_raw && !rst;

  always_ff @(posedge pclk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      cnt_q       <= 9'd0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      clr_busy_q  <= 1'b0;
      char_code_q <= 7'd0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      clr_busy_q  <= clr_busy_d;
      char_code_q <= mem[char_xy];
    end
  end

  assign char_code = char_code_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign clr_busy  = clr_busy_q;

endmodule

// File: tb/tb_text_buf_arbiter.sv
// Bench for text_buf_arbiter: one unsynchronised (u0) and one vblank-synchronised
// (u1) instance; expected acks and read-back data are queued and checked on output.
module tb_text_buf_arbiter;

  logic       pclk = 1'b0;
  logic       rst, vblnk, clr_req, req0, req1;
  logic [7:0] char_xy, addr0, addr1;
  logic [6:0] data0, data1;
  logic [6:0] cc0, cc1;
  logic       a00, a01, a10, a11, busy0, busy1;

  int         total = 0;
  int         bad   = 0;
  int         exp_ack0_q[$];
  int         exp_ack1_q[$];
  logic [14:0] rd_q[$];
  bit         mon0_en = 1'b1;
  bit         mon1_en = 1'b1;
  int         p0, p1;

  always #5 pclk = ~pclk;

  text_buf_arbiter #(.SYNC_WR(1'b0), .FILL_CODE(7'h20)) u0 (
    .pclk(pclk), .rst(rst), .vblnk_in(vblnk), .char_xy(char_xy), .char_code(cc0),
    .req0(req0), .addr0(addr0), .data0(data0), .ack0(a00),
    .req1(req1), .addr1(addr1), .data1(data1), .ack1(a01),
    .clr_req(clr_req), .clr_busy(busy0)
  );

  text_buf_arbiter #(.SYNC_WR(1'b1), .FILL_CODE(7'h20)) u1 (
    .pclk(pclk), .rst(rst), .vblnk_in(vblnk), .char_xy(char_xy), .char_code(cc1),
    .req0(req0), .addr0(addr0), .data0(data0), .ack0(a10),
    .req1(req1), .addr1(addr1), .data1(data1), .ack1(a11),
    .clr_req(clr_req), .clr_busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  always @(negedge pclk) begin
    if (mon0_en && (a00 || a01)) begin
      p0 = a01 ? 1 : 0;
      chk("one_ack0", 32'(a00) + 32'(a01), 32'd1);
      if (exp_ack0_q.size() == 0) chk("unexp_ack0", 32'(p0), 32'hff);
      else chk("ack_order0", 32'(p0), 32'(exp_ack0_q.pop_front()));
      $display("ack u0 port%0d", p0);
    end
  end

  always @(negedge pclk) begin
    if (mon1_en && (a10 || a11)) begin
      p1 = a11 ? 1 : 0;
      chk("one_ack1", 32'(a10) + 32'(a11), 32'd1);
      if (exp_ack1_q.size() == 0) chk("unexp_ack1", 32'(p1), 32'hff);
      else chk("ack_order1", 32'(p1), 32'(exp_ack1_q.pop_front()));
      $display("ack u1 port%0d", p1);
    end
  end

  task automatic wr(input int dut, input int port, input logic [7:0] a, input logic [6:0] d);
    logic got;
    got = 1'b0;
    if (dut == 0) exp_ack0_q.push_back(port);
    else          exp_ack1_q.push_back(port);
    if (port == 0) begin req0 = 1'b1; addr0 = a; data0 = d; end
    else           begin req1 = 1'b1; addr1 = a; data1 = d; end
    for (int i = 0; i < 20 && !got; i++) begin
      tick;
      if (dut == 0) got = (port == 0) ? a00 : a01;
      else          got = (port == 0) ? a10 : a11;
    end
    if (port == 0) req0 = 1'b0;
    else           req1 = 1'b0;
    chk("wr_acked", 32'(got), 32'd1);
    rd_q.push_back({a, d});
    $display("write u%0d port%0d addr=%02h data=%02h", dut, port, a, d);
  endtask

  task automatic drain(input int dut);
    logic [14:0] e;
    logic [6:0]  got;
    while (rd_q.size() > 0) begin
      e       = rd_q.pop_front();
      char_xy = e[14:7];
      tick;
      got = (dut == 0) ? cc0 : cc1;
      chk($sformatf("rd_%02h", e[14:7]), 32'(got), 32'(e[6:0]));
    end
  endtask

  task automatic clr_pulse;
    clr_req = 1'b1;
    tick;
    clr_req = 1'b0;
    chk("busy_start", 32'(busy1), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1, nack, nb, cnt;
    logic got;
    rst = 1'b1; vblnk = 1'b0; clr_req = 1'b0; char_xy = 8'h00;
    req0 = 1'b0; addr0 = 8'h00; data0 = 7'h00;
    req1 = 1'b0; addr1 = 8'h00; data1 = 7'h00;
    repeat (3) tick;
    rst = 1'b0;
    chk("rst_cc0", 32'(cc0), 32'd0);
    chk("rst_cc1", 32'(cc1), 32'd0);
    chk("rst_ack00", 32'(a00), 32'd0);
    chk("rst_ack01", 32'(a01), 32'd0);
    chk("rst_ack10", 32'(a10), 32'd0);
    chk("rst_ack11", 32'(a11), 32'd0);
    chk("rst_busy0", 32'(busy0), 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);

    // Unsynchronised single write with vblank low.
    wr(0, 0, 8'h12, 7'h41);
    tick;
    chk("ack_pulse", 32'(a00), 32'd0);
    chk("ack1_quiet", 32'(a01), 32'd0);
    drain(0);

    // Contention: both ports held for two grants each.
    rst = 1'b1; tick; rst = 1'b0;
    exp_ack0_q.push_back(0); exp_ack0_q.push_back(1);
    exp_ack0_q.push_back(0); exp_ack0_q.push_back(1);
    req0 = 1'b1; addr0 = 8'h20; data0 = 7'h10;
    req1 = 1'b1; addr1 = 8'h30; data1 = 7'h50;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 20 && (req0 || req1); i++) begin
      tick;
      if (a00) begin
        rd_q.push_back({addr0, data0});
        n0++;
        if (n0 == 2) req0 = 1'b0;
        else begin addr0 = 8'h21; data0 = 7'h11; end
      end
      if (a01) begin
        rd_q.push_back({addr1, data1});
        n1++;
        if (n1 == 2) req1 = 1'b0;
        else begin addr1 = 8'h31; data1 = 7'h51; end
      end
    end
    chk("grants0", 32'(n0), 32'd2);
    chk("grants1", 32'(n1), 32'd2);
    drain(0);
    chk("ack_q0_empty", 32'(exp_ack0_q.size()), 32'd0);
    mon0_en = 1'b0;

    // Vblank-synchronised write is held off until vblank.
    rst = 1'b1; tick; rst = 1'b0;
    vblnk = 1'b1;
    wr(1, 1, 8'h40, 7'h11);
    drain(1);
    vblnk = 1'b0;
    req1 = 1'b1; addr1 = 8'h40; data1 = 7'h22; char_xy = 8'h40;
    nack = 0;
    repeat (100) begin tick; nack += 32'(a11); end
    chk("no_ack_blank", 32'(nack), 32'd0);
    chk("mem_hold", 32'(cc1), 32'h11);
    exp_ack1_q.push_back(1);
    vblnk = 1'b1;
    tick;
    chk("ack_on_vblnk", 32'(a11), 32'd1);
    chk("rd_old", 32'(cc1), 32'h11);
    req1 = 1'b0;
    tick;
    chk("rd_new", 32'(cc1), 32'h22);

    // Full clear with a request arriving mid-clear.
    wr(1, 0, 8'h05, 7'h33);
    rd_q.delete();
    clr_pulse();
    req0 = 1'b1; addr0 = 8'h07; data0 = 7'h44;
    cnt = 0; nack = 0;
    for (int i = 0; i < 400 && busy1; i++) begin
      cnt++;
      nack += 32'(a10);
      tick;
    end
    chk("clr_len", 32'(cnt), 32'd256);
    chk("no_ack_clr", 32'(nack), 32'd0);
    exp_ack1_q.push_back(0);
    got = 1'b0;
    for (int i = 0; i < 5 && !got; i++) begin
      tick;
      got = a10;
    end
    chk("ack_after_clr", 32'(got), 32'd1);
    req0 = 1'b0;
    for (int a = 0; a < 256; a++)
      rd_q.push_back({8'(a), (a == 7) ? 7'h44 : 7'h20});
    drain(1);

    // Clear paused by vblank dropping after 100 writes.
    wr(1, 0, 8'h64, 7'h66);
    wr(1, 0, 8'h96, 7'h55);
    drain(1);
    clr_pulse();
    repeat (100) tick;
    vblnk = 1'b0;
    char_xy = 8'h64;
    nb = 0;
    repeat (50) begin tick; nb += 32'(busy1); end
    chk("pause_busy", 32'(nb), 32'd50);
    chk("cnt_hold", 32'(cc1), 32'h66);
    char_xy = 8'h63;
    tick;
    chk("rd63_done", 32'(cc1), 32'h20);
    vblnk = 1'b1;
    cnt = 0;
    for (int i = 0; i < 400 && busy1; i++) begin cnt++; tick; end
    chk("clr_rest", 32'(cnt), 32'd156);
    rd_q.push_back({8'h64, 7'h20});
    rd_q.push_back({8'h96, 7'h20});
    drain(1);

    // Reset in the middle of a clear.
    wr(1, 0, 8'hc8, 7'h77);
    wr(1, 1, 8'h32, 7'h02);
    drain(1);
    clr_pulse();
    repeat (50) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_busy", 32'(busy1), 32'd0);
    tick;
    chk("rst_idle", 32'(busy1), 32'd0);
    rd_q.push_back({8'h00, 7'h20});
    rd_q.push_back({8'h31, 7'h20});
    rd_q.push_back({8'h32, 7'h02});
    rd_q.push_back({8'hc8, 7'h77});
    drain(1);
    chk("ack_q1_empty", 32'(exp_ack1_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/text_buf_arbiter.md
Name: text_buf_arbiter

Overview:
- Owns the 256-entry character text buffer that feeds the on-screen text box renderer.
- The text box is 16 columns x 16 rows; the renderer's char_xy is {row[3:0], col[3:0]}.
- Arbitrates write access between two requesters (port 0: game/menu messages, port 1: score/status updater) and a whole-buffer clear engine.
- Serves the renderer's read lookup with fixed one-cycle latency.
- Optionally defers all writes to vertical blanking so no visible frame shows a half-updated buffer.

Parameters:
- SYNC_WR, 1, 1 = buffer writes commit only while vblnk_in=1; 0 = writes commit whenever granted.
- FILL_CODE, 7'h20, character code written to every entry by a clear (ASCII space).

Ports:
- pclk  input  1  pixel clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- vblnk_in  input  1  vertical blanking from the timing chain.
- char_xy  input  8  read address from the renderer, {row, col}.
- char_code  output  7  character code at char_xy, registered.
- req0  input  1  write request, port 0.
- addr0  input  8  write address, port 0.
- data0  input  7  write data, port 0.
- ack0  output  1  one-cycle pulse when the port 0 write commits.
- req1, addr1, data1, ack1  same as port 0, for port 1.
- clr_req  input  1  request a full-buffer clear (level-sampled).
- clr_busy  output  1  high while a clear is in progress.

Behaviour:
- Storage:
  - 256 x 7 single-write-port array; one write per cycle maximum.
  - Contents are not reset and are unchanged by rst.
- Read path:
  - char_code <= mem[char_xy] every cycle; latency 1 cycle, independent of writes.
  - Read and write to the same address in the same cycle: char_code returns the old data; the new data is visible from the next read.
- Reset values: char_code=0, ack0=0, ack1=0, clr_busy=0; FSM=IDLE; round-robin pointer last=1, so port 0 wins the first contention.
- Write enable gate: wr_ok = (SYNC_WR==0) | vblnk_in.
- FSM states: IDLE, CLEAR.
- IDLE, one decision per cycle, in priority order:
  - If clr_req=1: go to CLEAR with clear counter=0 and clr_busy=1 from the next cycle. No write this cycle; pending requests wait.
  - Else if wr_ok and any valid request: grant one port.
    - Valid request: reqN=1 and ackN=0 this cycle.
    - Both valid: grant the port != last.
    - One valid: grant that port.
  - Granted port N: mem[addrN] <= dataN, ackN=1 for exactly that cycle, last <= N.
  - The commit and the ack are the same cycle; the requester sees ack registered in the following cycle.
- Handshake rules:
  - Requester holds reqN, addrN, dataN stable until it samples ackN=1.
  - reqN still high in the cycle after ack is a new request. The valid-request rule forbids a back-to-back grant to the same port while the other port waits.
  - Never ack0 and ack1 in the same cycle.
- CLEAR:
  - Each cycle with wr_ok=1: mem[cnt] <= FILL_CODE, cnt++.
  - Cycles with wr_ok=0: pause; cnt holds.
  - After writing address 255: return to IDLE; clr_busy=0 in the following cycle.
  - Requests are not acked during CLEAR.
  - clr_req is ignored while in CLEAR; a still-high clr_req on return to IDLE starts another clear.
  - Minimum duration is 256 cycles with wr_ok held high.
- Reset mid-clear or mid-request: the FSM returns to IDLE immediately and the clear is abandoned. Entries already written keep FILL_CODE; the rest keep old data. No ack is issued in the reset cycle.
- Width rules: addresses are 8-bit. The clear counter is 9-bit, with bit 8 used as the done flag.

Test Plan:
- Reset, SYNC_WR=0; req0 with addr0=8'h12, data0=7'h41 -> ack0 pulses exactly 1 cycle; char_xy=8'h12 gives char_code=7'h41 one cycle later; ack1 stays 0.
- req0 and req1 asserted together and held for 4 grants, distinct addresses -> ack order 0,1,0,1; never both acks high.
- SYNC_WR=1, req1 asserted with vblnk_in=0 for 100 cycles -> no ack1, memory unchanged; vblnk_in rises -> ack1 in that cycle; data readable on the next cycle.
- clr_req pulse with vblnk_in=1 -> clr_busy high 256 cycles; all 256 addresses read 7'h20; req0 raised during clear is acked only after clr_busy falls.
- SYNC_WR=1, clear with vblnk_in dropping after 100 writes -> clr_busy stays 1 and the counter holds; resumes on vblnk_in=1; total 256 writes.
- rst asserted at clear cycle 50 -> next cycle clr_busy=0 and FSM idle; addresses 0-49 read 7'h20, address 200 retains its prior value.
